// File: rtl/tensor_wb_collector.sv
// Writeback collector: buffers a TILE_ROWS x L result tile, then streams it out as 32-bit beats.
// Optional macro TENSOR_WB_PERF_EN adds stall and tile performance counters.
module tensor_wb_collector #(
    parameter int L         = 8,
    parameter int WIDTH     = 32,
    parameter int TILE_ROWS = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mixed,
    input  logic [1:0]           cfg_addr_type,
    input  logic                 res_valid,
    input  logic [L*WIDTH-1:0]   res_data,
    input  logic                 res_last,
    output logic                 res_ready,
    output logic                 wr_enb,
    output logic [1:0]           addr_type,
    output logic [31:0]          wr_data,
    output logic                 wr_valid,
    input  logic                 wr_ready,
    output logic                 tile_done,
    output logic                 err_framing
`ifdef TENSOR_WB_PERF_EN
    ,
    output logic [31:0]          perf_stall_cnt,
    output logic [15:0]          perf_tile_cnt
`endif
);

    localparam int BEATS = TILE_ROWS * L;
    localparam int BW    = $clog2(BEATS) + 1;
    localparam int RW    = $clog2(TILE_ROWS);
    localparam int LW    = $clog2(L);

    localparam logic [BW-1:0] LAST_N   = BW'(BEATS - 1);
    localparam logic [BW-1:0] LAST_M   = BW'(BEATS / 2 - 1);
    localparam logic [BW-1:0] DIV_N    = BW'(L);
    localparam logic [BW-1:0] DIV_M    = BW'(L / 2);
    localparam logic [RW-1:0] ROW_LAST = RW'(TILE_ROWS - 1);

    typedef enum logic [1:0] {
        S_COLLECT,
        S_ISSUE,
        S_DRAIN
    } state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   row_cnt_q, row_cnt_d;
    logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
    logic            mode_q, mode_d;
    logic [1:0]      addr_type_q, addr_type_d;
    logic            err_q, err_d;
    logic            row_we;

    logic [L-1:0][WIDTH-1:0] tile_buf_q [TILE_ROWS];

    logic [RW-1:0]   row_sel;
    logic [LW-1:0]   lo_sel, hi_sel;
    logic [31:0]     lo_word;
    logic [15:0]     hi_half;
    logic [31:0]     beat_data;
    logic [BW-1:0]   beat_last;

    // Tile storage; contents are only meaningful between row capture and drain.
    always_ff @(posedge clk) begin
        if (row_we) tile_buf_q[row_cnt_q] <= res_data;
    end

    // Read path: mixed mode packs the low halves of an adjacent lane pair.
    always_comb begin
        if (mode_q) begin
            row_sel = RW'(beat_cnt_q / DIV_M);
            lo_sel  = LW'((beat_cnt_q % DIV_M) << 1);
            hi_sel  = LW'(((beat_cnt_q % DIV_M) << 1) | BW'(1));
        end else begin
            row_sel = RW'(beat_cnt_q / DIV_N);
            lo_sel  = LW'(beat_cnt_q % DIV_N);
            hi_sel  = LW'(beat_cnt_q % DIV_N);
        end
        lo_word   = tile_buf_q[row_sel][lo_sel][31:0];
        hi_half   = tile_buf_q[row_sel][hi_sel][15:0];
        beat_data = mode_q ? {hi_half, lo_word[15:0]} : lo_word;
        beat_last = mode_q ? LAST_M : LAST_N;
    end

    always_comb begin
        state_d     = state_q;
        row_cnt_d   = row_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        mode_d      = mode_q;
        addr_type_d = addr_type_q;
        err_d       = err_q;
        row_we      = 1'b0;
        res_ready   = 1'b0;
        wr_enb      = 1'b0;
        wr_valid    = 1'b0;
        tile_done   = 1'b0;
        case (state_q)
            S_COLLECT: begin
                res_ready = 1'b1;
                if (res_valid) begin
                    row_we = 1'b1;
                    if (row_cnt_q == '0) begin
                        mode_d      = mixed;
                        addr_type_d = cfg_addr_type;
                    end
                    // Misplaced or missing res_last flags an error but never shortens the tile.
                    if (res_last != (row_cnt_q == ROW_LAST)) err_d = 1'b1;
                    if (row_cnt_q == ROW_LAST) begin
                        row_cnt_d = '0;
                        state_d   = S_ISSUE;
                    end else begin
                        row_cnt_d = row_cnt_q + 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                wr_enb     = 1'b1;
                beat_cnt_d = '0;
                state_d    = S_DRAIN;
            end
            S_DRAIN: begin
                wr_valid = 1'b1;
                if (wr_ready) begin
                    if (beat_cnt_q == beat_last) begin
                        tile_done  = 1'b1;
                        beat_cnt_d = '0;
                        row_cnt_d  = '0;
                        state_d    = S_COLLECT;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_COLLECT;
            row_cnt_q   <= '0;
            beat_cnt_q  <= '0;
            mode_q      <= 1'b0;
            addr_type_q <= 2'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_cnt_q   <= row_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            mode_q      <= mode_d;
            addr_type_q <= addr_type_d;
            err_q       <= err_d;
        end
    end

    assign wr_data     = (state_q == S_DRAIN) ? beat_data : 32'd0;
    assign addr_type   = addr_type_q;
    assign err_framing = err_q;

`ifdef TENSOR_WB_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [15:0] perf_tile_q, perf_tile_d;

    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_tile_d  = perf_tile_q;
        if (wr_valid && !wr_ready && (perf_stall_q != 32'hFFFF_FFFF))
            perf_stall_d = perf_stall_q + 1'b1;
        if (tile_done) perf_tile_d = perf_tile_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_q <= '0;
            perf_tile_q  <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_tile_q  <= perf_tile_d;
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_tile_cnt  = perf_tile_q;
`endif

endmodule
